// File: rtl/sram_fifo_pkg.sv
// Shared sizing constants for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
   localparam int WIDTH    = 144;
   localparam int DEPTH    = 32;
   localparam int AW       = 5;
   localparam int OB_DEPTH = 3;
   localparam int CNT_W    = 6;
endpackage

// File: rtl/sram_fifo_outbuf.sv
// Small in-order register FIFO that receives SRAM read data and presents the head word.
module sram_fifo_outbuf #(
   parameter  int WIDTH = 144,
   parameter  int DEPTH = 3,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [OW-1:0]    o_occ
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [OW-1:0]    r_occ;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push = i_push && (r_occ != OW'(DEPTH));
   assign w_pop  = i_pop && (r_occ != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_tail <= ptr_inc(r_tail);
         if (w_pop)  r_head <= ptr_inc(r_head);
         r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
      end
   end

   // Data storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= i_data;
   end

   assign o_valid = (r_occ != '0);
   assign o_data  = r_mem[r_head];
   assign o_occ   = r_occ;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a dual-port synchronous SRAM (port 2 write, port 1 read)
// with a small output buffer that hides the one-cycle SRAM read latency.
module sram_fifo_ctrl #(
   parameter int WIDTH    = sram_fifo_pkg::WIDTH,
   parameter int DEPTH    = sram_fifo_pkg::DEPTH,
   parameter int AW       = sram_fifo_pkg::AW,
   parameter int OB_DEPTH = sram_fifo_pkg::OB_DEPTH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic [sram_fifo_pkg::CNT_W-1:0] count,
   output logic [AW-1:0]                  sram_a2,
   output logic                           sram_csb2,
   output logic                           sram_web2,
   output logic [WIDTH-1:0]               sram_i2,
   output logic [AW-1:0]                  sram_a1,
   output logic                           sram_csb1,
   output logic                           sram_oeb1,
   input  logic [WIDTH-1:0]               sram_o1
);
   import sram_fifo_pkg::*;

   localparam int OB_OW = $clog2(OB_DEPTH + 1);

   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_sram_used;
   logic             r_rd_pend;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_rd_issue;
   logic             w_pop;
   logic [OB_OW-1:0] w_ob_occ;
   logic [OB_OW-1:0] w_ob_occ_next;
   logic [AW:0]      w_sram_used_next;

   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign in_ready = !reset && (r_sram_used < (AW+1)'(DEPTH));
   assign w_push   = in_valid && in_ready;

   // Reserve an output-buffer slot for every read in flight, so issue never depends on out_ready.
   assign w_rd_issue = (r_sram_used != '0) && ((int'(w_ob_occ) + int'(r_rd_pend)) < OB_DEPTH);
   assign w_pop      = out_valid && out_ready;

   assign w_sram_used_next = r_sram_used + (AW+1)'(w_push) - (AW+1)'(w_rd_issue);
   assign w_ob_occ_next    = w_ob_occ + OB_OW'(r_rd_pend) - OB_OW'(w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_sram_used <= '0;
         r_rd_pend   <= 1'b0;
         r_count     <= '0;
      end else begin
         if (w_push)     r_wptr <= addr_inc(r_wptr);
         if (w_rd_issue) r_rptr <= addr_inc(r_rptr);
         r_sram_used <= w_sram_used_next;
         r_rd_pend   <= w_rd_issue;
         r_count     <= CNT_W'(w_sram_used_next) + CNT_W'(w_rd_issue) + CNT_W'(w_ob_occ_next);
      end
   end

   assign sram_a2   = r_wptr;
   assign sram_i2   = in_data;
   assign sram_csb2 = !w_push;
   assign sram_web2 = !w_push;
   assign sram_a1   = r_rptr;
   assign sram_csb1 = !w_rd_issue;
   assign sram_oeb1 = 1'b0;
   assign count     = r_count;

   sram_fifo_outbuf #(
      .WIDTH (WIDTH),
      .DEPTH (OB_DEPTH)
   ) u_outbuf (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_rd_pend),
      .i_data  (sram_o1),
      .i_pop   (w_pop),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_occ   (w_ob_occ)
   );
endmodule
